// File: rtl/sbus_pkg.sv
// Shared S-bus widths, acceptance-state encoding and the buffered write entry type.
// Pure declarations; no timing or flow-control behaviour of its own.
package sbus_pkg;
  localparam int SBUS_AW = 48;
  localparam int SBUS_DW = 176;

  typedef enum logic {
    AIDLE = 1'b0,
    ACK   = 1'b1
  } sbus_astate_e;

  typedef struct packed {
    logic [SBUS_AW-1:0] addr;
    logic [SBUS_DW-1:0] data;
  } sbus_wentry_t;
endpackage

// File: rtl/sbus_wfifo.sv
// Synchronous FIFO of S-bus write entries; a push becomes the visible head one cycle later.
// Backpressure: a push while full is taken only when a pop happens in the same cycle.
module sbus_wfifo
  import sbus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  sbus_wentry_t           i_dat,
  input  logic                   i_pop,
  output sbus_wentry_t           o_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);

  sbus_wentry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sbus_wresponder.sv
// S-bus write target: request sampled in N is acked in N+1, entries reach storage one cycle after capture.
// Full FIFO holds the request unacked until a pop frees a slot; storage stalls hold the head stable.
module sbus_wresponder
  import sbus_pkg::*;
#(
  parameter int                 DEPTH      = 4,
  parameter logic [SBUS_AW-1:0] ADDR_BASE  = 48'h0,
  parameter logic [SBUS_AW-1:0] ADDR_LIMIT = 48'hFFFF_FFFF_FFFF
) (
  input  logic               Sclk,
  input  logic               Sreset_n,
  input  logic               Swrequest,
  input  logic [SBUS_AW-1:0] Swaddr,
  input  logic [SBUS_DW-1:0] Swdata,
  output logic               Swack,
  output logic               mem_wen,
  output logic [SBUS_AW-1:0] mem_waddr,
  output logic [SBUS_DW-1:0] mem_wdata,
  input  logic               mem_wready,
  input  logic               clr,
  output logic [15:0]        wr_cnt,
  output logic               err,
  output logic               busy
);
  sbus_astate_e           r_state;
  sbus_astate_e           w_next;
  logic [15:0]            r_wr_cnt;
  logic                   r_err;
  logic                   w_below;
  logic                   w_above;
  logic                   w_in_range;
  logic                   w_room;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;
  sbus_wentry_t           w_in_entry;
  sbus_wentry_t           w_head;

  // Borrow bits of 49-bit subtractions give an unsigned compare with no constant-compare hazards.
  assign w_below    = 1'((({1'b0, Swaddr} - {1'b0, ADDR_BASE}) >> SBUS_AW));
  assign w_above    = 1'((({1'b0, ADDR_LIMIT} - {1'b0, Swaddr}) >> SBUS_AW));
  assign w_in_range = !w_below && !w_above;

  assign w_pop  = mem_wen && mem_wready;
  assign w_room = !w_full || w_pop;

  always_ff @(posedge Sclk or negedge Sreset_n) begin
    if (!Sreset_n) r_state <= AIDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      AIDLE:   if (Swrequest && (!w_in_range || w_room)) w_next = ACK;
      ACK:     w_next = AIDLE;
      default: w_next = AIDLE;
    endcase
  end

  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    Swack  = 1'b0;
    case (r_state)
      AIDLE: begin
        w_push = Swrequest && w_in_range && w_room;
        w_drop = Swrequest && !w_in_range;
      end
      ACK:     Swack = 1'b1;
      default: Swack = 1'b0;
    endcase
  end

  always_ff @(posedge Sclk or negedge Sreset_n) begin
    if (!Sreset_n) begin
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else if (clr) begin
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ACK) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_drop)         r_err    <= 1'b1;
    end
  end

  assign w_in_entry = '{addr: Swaddr, data: Swdata};

  sbus_wfifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (Sclk),
    .i_rst_n (Sreset_n),
    .i_push  (w_push),
    .i_dat   (w_in_entry),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  // Head is masked while empty so the storage port idles at zero.
  assign mem_wen   = !w_empty;
  assign mem_waddr = w_empty ? '0 : w_head.addr;
  assign mem_wdata = w_empty ? '0 : w_head.data;
  assign wr_cnt    = r_wr_cnt;
  assign err       = r_err;
  assign busy      = (w_fifo_count != '0) || (r_state == ACK);
endmodule

// File: tb/tb_sbus_wresponder.sv
// Bench for sbus_wresponder: vector table of single writes, then hand-built sequences for
// backpressure, push/pop at full, clear priority, reset mid-transfer and counter wrap.
module tb_sbus_wresponder;
  import sbus_pkg::*;

  localparam logic [47:0] LIMIT = 48'hFF;

  logic         Sclk;
  logic         Sreset_n;
  logic         Swrequest;
  logic [47:0]  Swaddr;
  logic [175:0] Swdata;
  logic         Swack;
  logic         mem_wen;
  logic [47:0]  mem_waddr;
  logic [175:0] mem_wdata;
  logic         mem_wready;
  logic         clr;
  logic [15:0]  wr_cnt;
  logic         err;
  logic         busy;

  sbus_wresponder #(.DEPTH(4), .ADDR_BASE(48'h0), .ADDR_LIMIT(LIMIT)) dut (
    .Sclk       (Sclk),
    .Sreset_n   (Sreset_n),
    .Swrequest  (Swrequest),
    .Swaddr     (Swaddr),
    .Swdata     (Swdata),
    .Swack      (Swack),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .clr        (clr),
    .wr_cnt     (wr_cnt),
    .err        (err),
    .busy       (busy)
  );

  typedef struct {
    logic [47:0]  addr;
    logic [175:0] data;
    logic         in_rng;
  } vec_t;

  vec_t         tbl [6];
  sbus_wentry_t sb_q [$];
  sbus_wentry_t mon_e;
  int           n_tests;
  int           n_fail;
  logic [15:0]  exp_cnt;
  logic         exp_err;
  int           lat;

  initial begin
    Sclk = 1'b0;
    forever #5 Sclk = ~Sclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits on negedges for Swack; returns cycles waited, or -1 after the bound.
  task automatic wait_ack(input int bound, output int cycles);
    cycles = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge Sclk);
      if (Swack) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [47:0] a, input logic [175:0] d,
                          input logic in_rng, input logic exp_wen);
    int c;
    Swrequest = 1'b1;
    Swaddr    = a;
    Swdata    = d;
    if (in_rng) sb_q.push_back('{addr: a, data: d});
    wait_ack(20, c);
    chk("ack_latency", c, 1);
    chk("wen_at_ack", mem_wen, exp_wen);
    Swrequest = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    if (!in_rng) exp_err = 1'b1;
    @(negedge Sclk);
    chk("ack_one_cycle", Swack, 0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_cnt    = '0;
    exp_err    = 1'b0;
    Sreset_n   = 1'b0;
    Swrequest  = 1'b0;
    Swaddr     = '0;
    Swdata     = '0;
    mem_wready = 1'b1;
    clr        = 1'b0;

    tbl[0] = '{48'h10, 176'hA5, 1'b1};
    tbl[1] = '{48'hFF, 176'hDEAD_BEEF_0123_4567_89AB_CDEF, 1'b1};
    tbl[2] = '{48'h0, {11{16'hC3A5}}, 1'b1};
    tbl[3] = '{48'h100, 176'h1, 1'b0};
    tbl[4] = '{48'hFFFF_FFFF_FFFF, 176'h2, 1'b0};
    tbl[5] = '{48'hFE, {176{1'b1}}, 1'b1};

    fork
      forever begin
        @(negedge Sclk);
        #1;
        if (Sreset_n && mem_wen && mem_wready) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_write", mem_waddr, 48'hFFFF_FFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            chk("sb_addr", mem_waddr, mon_e.addr);
            chk("sb_data", mem_wdata, mon_e.data);
          end
        end
      end
    join_none

    repeat (2) @(negedge Sclk);
    Sreset_n = 1'b1;
    @(negedge Sclk);
    chk("rst_swack", Swack, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cnt", wr_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].in_rng, tbl[i].in_rng);
      chk("tbl_cnt", wr_cnt, exp_cnt);
      chk("tbl_err", err, exp_err);
    end

    // clr lands in the ACK cycle: the clear wins over the increment.
    Swrequest = 1'b1;
    Swaddr    = 48'h20;
    Swdata    = 176'h77;
    sb_q.push_back('{addr: 48'h20, data: 176'h77});
    wait_ack(20, lat);
    chk("clr_ack_latency", lat, 1);
    Swrequest = 1'b0;
    clr       = 1'b1;
    @(negedge Sclk);
    clr     = 1'b0;
    exp_cnt = '0;
    exp_err = 1'b0;
    chk("clr_cnt", wr_cnt, 0);
    chk("clr_err", err, 0);

    // Back-to-back with storage stalled: four fill the FIFO, the fifth waits.
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_write(48'(i), 176'(i + 'h100), 1'b1, 1'b1);
    end
    Swrequest = 1'b1;
    Swaddr    = 48'h4;
    Swdata    = 176'h104;
    sb_q.push_back('{addr: 48'h4, data: 176'h104});
    wait_ack(5, lat);
    chk("full_no_ack", lat, -1);
    chk("full_wen", mem_wen, 1);
    chk("full_head_stable", mem_waddr, 48'h0);
    chk("full_busy", busy, 1);
    mem_wready = 1'b1;
    wait_ack(20, lat);
    chk("full_release_latency", lat, 1);
    chk("pushpop_count", dut.w_fifo_count, 4);
    Swrequest = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    @(negedge Sclk);
    chk("full_ack_one_cycle", Swack, 0);
    do_write(48'h5, 176'h105, 1'b1, 1'b1);
    chk("b2b_cnt", wr_cnt, exp_cnt);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Sclk);
      if (!busy) begin
        lat = i;
        break;
      end
    end
    chk("drain_done", (lat > 0), 1);
    chk("drain_queue_empty", sb_q.size(), 0);

    // Reset with three entries buffered and Swack high.
    mem_wready = 1'b0;
    do_write(48'h30, 176'h30, 1'b1, 1'b1);
    do_write(48'h31, 176'h31, 1'b1, 1'b1);
    Swrequest = 1'b1;
    Swaddr    = 48'h32;
    Swdata    = 176'h32;
    wait_ack(20, lat);
    chk("rmid_ack_seen", lat, 1);
    #2;
    Sreset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rmid_swack", Swack, 0);
    chk("rmid_wen", mem_wen, 0);
    chk("rmid_waddr", mem_waddr, 0);
    chk("rmid_cnt", wr_cnt, 0);
    chk("rmid_busy", busy, 0);
    Swrequest = 1'b0;
    exp_cnt   = '0;
    exp_err   = 1'b0;
    @(negedge Sclk);
    Sreset_n   = 1'b1;
    mem_wready = 1'b1;
    @(negedge Sclk);
    do_write(48'h42, 176'h4242, 1'b1, 1'b1);
    chk("post_rst_cnt", wr_cnt, 1);

    // Counter wrap from 16'hFFFF.
    force dut.r_wr_cnt = 16'hFFFF;
    #1;
    release dut.r_wr_cnt;
    @(negedge Sclk);
    chk("wrap_preload", wr_cnt, 16'hFFFF);
    do_write(48'h50, 176'h50, 1'b1, 1'b1);
    chk("wrap_cnt", wr_cnt, 0);

    repeat (4) @(negedge Sclk);
    chk("final_queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
